// File: rtl/scc_mem_port.sv
// Initiator-side data-memory port: turns load/store requests into one-cycle read/write
// strobes on a word-wide big-endian memory, using read-modify-write for sub-word stores.
module scc_mem_port #(
  parameter int unsigned MEM_BYTES = 65536
) (
  input  logic        mem_Clk,
  input  logic        mem_Rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  input  logic        halt_req,
  output logic        halt_f,
  output logic [31:0] data_memory_a,
  output logic        data_memory_read,
  output logic        data_memory_write,
  output logic [31:0] data_memory_out_v,
  input  logic [31:0] data_memory_in_v,
  output logic [2:0]  dbg_state
);

  // Handshake: a request transfers on a posedge where req_valid and req_ready are both high;
  // exactly one resp_valid pulse follows, and req_ready stays low until then.
  typedef enum logic [2:0] {IDLE, READ, CAPTURE, WRITE, WDONE, RESP, HALTED} state_e;

  state_e      state_q, state_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic        sgn_q, sgn_d;
  logic [1:0]  lane_q, lane_d;
  logic [15:0] wdata_q, wdata_d;
  logic [31:0] a_q, a_d;
  logic [31:0] out_v_q, out_v_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;
  logic        resp_valid_q, resp_valid_d;
  logic        rd_strobe_q, rd_strobe_d;
  logic        wr_strobe_q, wr_strobe_d;
  logic        halt_f_q, halt_f_d;
  logic        req_ready_q, req_ready_d;

  logic        req_err;
  logic [4:0]  sh_b, sh_h;
  logic [31:0] shifted, load_val, merged;

  always_comb begin
    req_err = (req_size == 2'd3)
           || (req_size == 2'd1 && req_addr[0])
           || (req_size == 2'd2 && req_addr[1:0] != 2'b00)
           || (({req_addr[31:2], 2'b00} + 32'd3) >= MEM_BYTES);
  end

  // Big-endian lanes: byte k sits at bits [31-8k -: 8], halfword 0 is the upper half.
  always_comb begin
    sh_b    = {~lane_q, 3'b000};
    sh_h    = {~lane_q[1], 4'b0000};
    shifted = data_memory_in_v >> ((size_q == 2'd0) ? sh_b : sh_h);
    case (size_q)
      2'd0:    load_val = {{24{sgn_q & shifted[7]}}, shifted[7:0]};
      2'd1:    load_val = {{16{sgn_q & shifted[15]}}, shifted[15:0]};
      default: load_val = data_memory_in_v;
    endcase
    if (size_q == 2'd0)
      merged = (data_memory_in_v & ~(32'h0000_00FF << sh_b)) | ({24'b0, wdata_q[7:0]} << sh_b);
    else
      merged = (data_memory_in_v & ~(32'h0000_FFFF << sh_h)) | ({16'b0, wdata_q} << sh_h);
  end

  always_comb begin
    state_d      = state_q;
    wr_d         = wr_q;
    size_d       = size_q;
    sgn_d        = sgn_q;
    lane_d       = lane_q;
    wdata_d      = wdata_q;
    a_d          = a_q;
    out_v_d      = out_v_q;
    resp_rdata_d = 32'b0;
    resp_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (halt_req) begin
          state_d = HALTED;
        end else if (req_valid && req_ready_q) begin
          wr_d    = req_write;
          size_d  = req_size;
          sgn_d   = req_signed;
          lane_d  = req_addr[1:0];
          wdata_d = req_wdata[15:0];
          a_d     = {req_addr[31:2], 2'b00};
          if (req_err) begin
            state_d    = RESP;
            resp_err_d = 1'b1;
          end else if (req_write && req_size == 2'd2) begin
            state_d = WRITE;
            out_v_d = req_wdata;
          end else begin
            state_d = READ;
          end
        end
      end
      READ:    state_d = CAPTURE;
      CAPTURE: begin
        if (wr_q) begin
          out_v_d = merged;
          state_d = WRITE;
        end else begin
          resp_rdata_d = load_val;
          state_d      = RESP;
        end
      end
      WRITE:   state_d = WDONE;
      WDONE:   state_d = RESP;
      RESP:    state_d = halt_req ? HALTED : IDLE;
      HALTED:  state_d = HALTED;
      default: state_d = IDLE;
    endcase
    rd_strobe_d  = (state_d == READ);
    wr_strobe_d  = (state_d == WRITE);
    resp_valid_d = (state_d == RESP);
    halt_f_d     = (state_d == HALTED);
    req_ready_d  = (state_d == IDLE) && !halt_req;
  end

  always_ff @(posedge mem_Clk or negedge mem_Rst_n) begin
    if (!mem_Rst_n) begin
      state_q      <= IDLE;
      wr_q         <= 1'b0;
      size_q       <= 2'b0;
      sgn_q        <= 1'b0;
      lane_q       <= 2'b0;
      wdata_q      <= 16'b0;
      a_q          <= 32'b0;
      out_v_q      <= 32'b0;
      resp_rdata_q <= 32'b0;
      resp_err_q   <= 1'b0;
      resp_valid_q <= 1'b0;
      rd_strobe_q  <= 1'b0;
      wr_strobe_q  <= 1'b0;
      halt_f_q     <= 1'b0;
      req_ready_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      wr_q         <= wr_d;
      size_q       <= size_d;
      sgn_q        <= sgn_d;
      lane_q       <= lane_d;
      wdata_q      <= wdata_d;
      a_q          <= a_d;
      out_v_q      <= out_v_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      resp_valid_q <= resp_valid_d;
      rd_strobe_q  <= rd_strobe_d;
      wr_strobe_q  <= wr_strobe_d;
      halt_f_q     <= halt_f_d;
      req_ready_q  <= req_ready_d;
    end
  end

  assign req_ready         = req_ready_q;
  assign resp_valid        = resp_valid_q;
  assign resp_err          = resp_err_q;
  assign resp_rdata        = resp_rdata_q;
  assign halt_f            = halt_f_q;
  assign data_memory_a     = a_q;
  assign data_memory_read  = rd_strobe_q;
  assign data_memory_write = wr_strobe_q;
  assign data_memory_out_v = out_v_q;
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_scc_mem_port.sv
// Directed bench for scc_mem_port: a word-memory model, request driver tasks and a
// response scoreboard that checks data, error flag and latency from the accept cycle.
module tb_scc_mem_port;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'b0;
  logic [31:0] req_wdata = 32'b0;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        halt_req = 1'b0;
  logic        halt_f;
  logic [31:0] dm_a, dm_out;
  logic        dm_read, dm_write;
  logic [31:0] dm_in = 32'b0;
  logic [2:0]  dbg_state;

  scc_mem_port #(.MEM_BYTES(32'h0000_FFFC)) dut (
    .mem_Clk(clk), .mem_Rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .halt_req(halt_req), .halt_f(halt_f),
    .data_memory_a(dm_a), .data_memory_read(dm_read), .data_memory_write(dm_write),
    .data_memory_out_v(dm_out), .data_memory_in_v(dm_in), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_vec = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // memory model: reads and writes act in the strobe cycle
  logic [31:0] mem [logic [31:0]];
  always @(negedge clk) begin
    if (dm_read) dm_in = mem.exists(dm_a) ? mem[dm_a] : 32'b0;
    if (dm_write) mem[dm_a] = dm_out;
  end

  // scoreboard: {latency[3:0], err, rdata}
  logic [36:0] exp_q[$];
  int acc_cyc = 0, n_rd = 0, n_wr = 0, rd_lat = 0, wr_lat = 0, resp_cnt = 0;
  logic [31:0] wr_data = 32'b0, last_a = 32'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (req_valid && req_ready) begin
        acc_cyc = cyc; n_rd = 0; n_wr = 0;
      end
      if (dm_read && dm_write) begin
        n_fail++;
        $display("FAIL strobe_overlap: read=%b write=%b both high", dm_read, dm_write);
      end
      if (dm_read) begin n_rd++; rd_lat = cyc - acc_cyc; last_a = dm_a; end
      if (dm_write) begin n_wr++; wr_lat = cyc - acc_cyc; wr_data = dm_out; last_a = dm_a; end
      if (!resp_valid && (resp_err || resp_rdata != 32'b0)) begin
        n_fail++;
        $display("FAIL resp_idle: err=%b rdata=%h required 0/0", resp_err, resp_rdata);
      end
      if (resp_valid) begin
        resp_cnt++;
        if (exp_q.size() == 0) begin
          n_vec++; n_fail++;
          $display("FAIL unexpected_resp: err=%b rdata=%h with nothing expected", resp_err, resp_rdata);
        end else begin
          logic [36:0] e;
          e = exp_q.pop_front();
          chk("resp_err", {31'b0, resp_err}, {31'b0, e[32]});
          chk("resp_rdata", resp_rdata, e[31:0]);
          chk("resp_latency", cyc - acc_cyc, {28'b0, e[36:33]});
        end
      end
    end
  end

  // driver tasks
  task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] addr, input logic [31:0] wd);
    int n;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = addr; req_wdata = wd;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready && n < 20);
    if (!req_ready) begin
      n_vec++; n_fail++;
      $display("FAIL accept_timeout: req_ready=%b required 1", req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic exp_err, input logic [31:0] exp_rd, input int lat,
                        input int exp_nrd, input int exp_nwr, input int exp_wrlat,
                        input logic [31:0] exp_wdata);
    int base, n;
    logic [3:0] l4;
    l4 = lat[3:0];
    exp_q.push_back({l4, exp_err, exp_rd});
    base = resp_cnt;
    issue(w, sz, sg, addr, wd);
    n = 0;
    while (resp_cnt == base && n < 30) begin @(posedge clk); n++; end
    if (resp_cnt == base) begin
      n_vec++; n_fail++;
      $display("FAIL resp_timeout: no resp_valid for addr %h", addr);
      void'(exp_q.pop_front());
    end
    chk("read_pulses", n_rd, exp_nrd);
    chk("write_pulses", n_wr, exp_nwr);
    if (exp_nrd > 0) chk("read_cycle", rd_lat, 1);
    if (exp_nwr > 0) begin
      chk("write_cycle", wr_lat, exp_wrlat);
      chk("write_data", wr_data, exp_wdata);
    end
    if (exp_nrd + exp_nwr > 0) chk("mem_addr", last_a, {addr[31:2], 2'b00});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

  initial begin
    int n;
    mem[32'h100] = 32'h1122_3344;
    mem[32'h104] = 32'h80FF_0000;
    #12;
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_outputs", {28'b0, resp_valid, resp_err, dm_read, dm_write}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_a", dm_a, 32'd0);
    chk("rst_halt_f", {31'b0, halt_f}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // word load
    do_req(0, 2'd2, 0, 32'h100, 32'h0, 0, 32'h1122_3344, 3, 1, 0, 0, 32'h0);
    // sub-word loads on 0x80FF0000
    do_req(0, 2'd0, 1, 32'h104, 32'h0, 0, 32'hFFFF_FF80, 3, 1, 0, 0, 32'h0);
    do_req(0, 2'd0, 0, 32'h105, 32'h0, 0, 32'h0000_00FF, 3, 1, 0, 0, 32'h0);
    do_req(0, 2'd1, 1, 32'h104, 32'h0, 0, 32'hFFFF_80FF, 3, 1, 0, 0, 32'h0);
    do_req(0, 2'd1, 0, 32'h106, 32'h0, 0, 32'h0000_0000, 3, 1, 0, 0, 32'h0);
    do_req(0, 2'd0, 1, 32'h105, 32'h0, 0, 32'hFFFF_FFFF, 3, 1, 0, 0, 32'h0);
    // read-modify-write stores
    do_req(1, 2'd0, 0, 32'h101, 32'h0000_00AB, 0, 32'h0, 5, 1, 1, 3, 32'h11AB_3344);
    do_req(0, 2'd2, 0, 32'h100, 32'h0, 0, 32'h11AB_3344, 3, 1, 0, 0, 32'h0);
    do_req(1, 2'd1, 0, 32'h106, 32'hFFFF_1234, 0, 32'h0, 5, 1, 1, 3, 32'h80FF_1234);
    do_req(1, 2'd0, 0, 32'h107, 32'h0000_0056, 0, 32'h0, 5, 1, 1, 3, 32'h80FF_1256);
    do_req(0, 2'd2, 0, 32'h104, 32'h0, 0, 32'h80FF_1256, 3, 1, 0, 0, 32'h0);
    // errors: misaligned word, misaligned half, bad size, out of range
    do_req(0, 2'd2, 0, 32'h102, 32'h0, 1, 32'h0, 1, 0, 0, 0, 32'h0);
    do_req(1, 2'd1, 0, 32'h103, 32'h1234, 1, 32'h0, 1, 0, 0, 0, 32'h0);
    do_req(0, 2'd3, 0, 32'h100, 32'h0, 1, 32'h0, 1, 0, 0, 0, 32'h0);
    do_req(0, 2'd2, 0, 32'h0000_FFFC, 32'h0, 1, 32'h0, 1, 0, 0, 0, 32'h0);
    // last in-range word
    do_req(0, 2'd2, 0, 32'h0000_FFF8, 32'h0, 0, 32'h0, 3, 1, 0, 0, 32'h0);

    // reset during the write cycle of a byte store
    issue(1, 2'd0, 0, 32'h104, 32'h0000_0077);
    n = 0;
    while (!dm_write && n < 10) begin @(negedge clk); n++; end
    chk("rmw_write_seen", {31'b0, dm_write}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_strobes", {30'b0, dm_read, dm_write}, 32'd0);
    chk("mid_rst_resp", {30'b0, resp_valid, resp_err}, 32'd0);
    chk("mid_rst_mem_a", dm_a, 32'd0);
    chk("mid_rst_out_v", dm_out, 32'd0);
    chk("mid_rst_req_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_req_ready", {31'b0, req_ready}, 32'd1);
    do_req(0, 2'd2, 0, 32'h100, 32'h0, 0, 32'h11AB_3344, 3, 1, 0, 0, 32'h0);

    // word store with HALT arriving one cycle after accept
    exp_q.push_back({4'd3, 1'b0, 32'h0});
    issue(1, 2'd2, 0, 32'h200, 32'hDEAD_BEEF);
    halt_req = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 3) chk("halt_f_at_c3", {31'b0, halt_f}, 32'd0);
      if (i == 4) chk("halt_f_at_c4", {31'b0, halt_f}, 32'd1);
    end
    chk("halt_write_cycle", wr_lat, 32'd1);
    chk("halt_write_data", wr_data, 32'hDEAD_BEEF);
    chk("halt_mem_word", mem.exists(32'h200) ? mem[32'h200] : 32'h0, 32'hDEAD_BEEF);
    chk("halt_resp_drained", exp_q.size(), 32'd0);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_addr = 32'h100;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("halted_req_ready", {31'b0, req_ready}, 32'd0);
      chk("halted_halt_f", {31'b0, halt_f}, 32'd1);
      chk("halted_strobes", {30'b0, dm_read, dm_write}, 32'd0);
    end
    req_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
